piso_serializer: RTL

Parallel-in, serial-out converter: accepts an 8-bit word over a valid/ready handshake and emits it as a stream of 2-bit symbols, most-significant symbol first, with first/last framing. It is the transmit-side counterpart of the SIPO receiver and feeds its 2-bit serial input directly. Downstream back-pressure is honoured on every symbol, and back-to-back words stream without bubbles.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_serializer.sv | 100 ++++++++++
 2 files changed

// File: rtl/piso_pkg.sv
// Shared types and sizing for the 2-bit-symbol PISO serializer.
// The default word/symbol sizes fix NSYM and the counter width.
package piso_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int SYM_W_DEF  = 2;
    localparam int NSYM       = DATA_W_DEF / SYM_W_DEF;
    localparam int CNT_W      = $clog2(NSYM + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Parity symbol: the parity bit in the LSB, zeros above it.
    function automatic logic [SYM_W_DEF-1:0] parity_sym(input logic par);
        return {{(SYM_W_DEF-1){1'b0}}, par};
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// 8-bit word -> 2-bit symbols MSB first with first/last framing; first symbol one edge after accept,
// back-to-back words stream bubble-free, out_ready stalls hold all outputs. PISO_PARITY_EN appends a parity symbol.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SYM_W  = SYM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_pi_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SYM_W-1:0]  out_so_symbol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

`ifdef PISO_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSYM - 1);
`endif

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               advance;
`ifdef PISO_PARITY_EN
    logic               parity_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        out_valid     = (state == SHIFT);
        out_first     = out_valid && (cnt == '0);
        out_last      = out_valid && (cnt == LAST_CNT);
        busy          = out_valid;
        out_so_symbol = '0;
        if (out_valid) begin
            out_so_symbol = shift_reg[DATA_W-1 -: SYM_W];
`ifdef PISO_PARITY_EN
            if (cnt == CNT_W'(NSYM)) begin
                out_so_symbol = SYM_W'(parity_sym(parity_q));
            end
`endif
        end
        // Reload on the last-symbol handshake keeps consecutive words gap-free.
        in_ready = !reset && ((state == IDLE) || (out_last && out_ready));
        accept   = in_valid && in_ready;
        advance  = out_valid && out_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (advance && out_last) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            cnt       <= '0;
`ifdef PISO_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (accept) begin
            shift_reg <= in_pi_word;
            cnt       <= '0;
`ifdef PISO_PARITY_EN
            parity_q  <= ^in_pi_word;
`endif
        end else if (advance) begin
            shift_reg <= shift_reg << SYM_W;
            cnt       <= cnt + 1'b1;
        end
    end

endmodule
